// File: rtl/switch_game_core.sv
// Switch-reaction game engine: one-hot LED prompts, score/lives/countdown, retained high score.
// Optional macro STREAK_BONUS_EN adds a streak counter (output streak) that doubles the award after four hits in a row.
module switch_game_core #(
    parameter int          N_SW         = 10,
    parameter int          SCORE_W      = 7,
    parameter int          TIME_W       = 6,
    parameter int          GAME_SECONDS = 20,
    parameter int          CLK_HZ       = 50000000,
    parameter int          LIVES        = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [N_SW-1:0]    sw,
    output logic [N_SW-1:0]    led,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [TIME_W-1:0]  time_left,
    output logic [2:0]         lives_left,
`ifdef STREAK_BONUS_EN
    output logic [2:0]         streak,
`endif
    output logic               playing,
    output logic               game_over
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PROMPT = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_OVER   = 2'd3;

    localparam int                 CNT_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int                 SUM_W     = SCORE_W + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLK_HZ - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [N_SW-1:0]    sw_meta_reg, sw_s_reg;
    logic               start_meta_reg, start_s_reg, start_d_reg;
    logic [15:0]        lfsr_reg;
    logic [1:0]         state_reg, state_next;
    logic [N_SW-1:0]    led_reg, led_next;
    logic [N_SW-1:0]    base_reg, base_next;
    logic [N_SW-1:0]    target_reg, target_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [SCORE_W-1:0] high_reg, high_next;
    logic [TIME_W-1:0]  time_reg, time_next;
    logic [2:0]         lives_reg, lives_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         award;
    logic [SUM_W-1:0]   score_sum;
    logic [15:0]        idx;
    logic [N_SW-1:0]    prompt_onehot;
    logic               start_p, in_play, tick, end_game, lfsr_fb;

    assign start_p = start_s_reg & ~start_d_reg;
    assign in_play = (state_reg == S_PROMPT) || (state_reg == S_WAIT);
    assign tick    = in_play && (cnt_reg == CNT_LAST);
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    assign idx     = lfsr_reg % 16'(N_SW);

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_onehot
        assign prompt_onehot[gi] = (idx == 16'(gi));
    end

`ifdef STREAK_BONUS_EN
    logic [2:0] streak_reg, streak_next;
    assign award  = (streak_reg == 3'd4) ? 2'd2 : 2'd1;
    assign streak = streak_reg;
`else
    assign award = 2'd1;
`endif

    assign score_sum = {1'b0, score_reg} + SUM_W'(award);

    always_comb begin
        state_next  = state_reg;
        led_next    = led_reg;
        base_next   = base_reg;
        target_next = target_reg;
        score_next  = score_reg;
        high_next   = high_reg;
        time_next   = time_reg;
        lives_next  = lives_reg;
        cnt_next    = cnt_reg;
        end_game    = 1'b0;
`ifdef STREAK_BONUS_EN
        streak_next = streak_reg;
`endif
        if (start_p) begin
            // A restart beats any answer or tick landing in the same cycle.
            state_next = S_PROMPT;
            led_next   = '0;
            score_next = '0;
            time_next  = TIME_W'(GAME_SECONDS);
            lives_next = 3'(LIVES);
            cnt_next   = '0;
`ifdef STREAK_BONUS_EN
            streak_next = '0;
`endif
        end else begin
            if (in_play)
                cnt_next = tick ? '0 : cnt_reg + 1'b1;
            case (state_reg)
                S_IDLE: led_next = '0;
                S_PROMPT: begin
                    base_next   = sw_s_reg;
                    target_next = sw_s_reg ^ prompt_onehot;
                    led_next    = prompt_onehot;
                    state_next  = S_WAIT;
                end
                S_WAIT: begin
                    if (sw_s_reg == target_reg) begin
                        score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
                        state_next = S_PROMPT;
`ifdef STREAK_BONUS_EN
                        if (streak_reg < 3'd4)
                            streak_next = streak_reg + 3'd1;
`endif
                    end else if (sw_s_reg != base_reg) begin
                        lives_next = (lives_reg != 3'd0) ? lives_reg - 3'd1 : 3'd0;
                        state_next = S_PROMPT;
                        end_game   = (lives_reg <= 3'd1);
`ifdef STREAK_BONUS_EN
                        streak_next = '0;
`endif
                    end
                end
                default: ;
            endcase
            if (tick) begin
                time_next = (time_reg != '0) ? time_reg - 1'b1 : '0;
                if (time_reg <= TIME_W'(1))
                    end_game = 1'b1;
            end
            // The same-cycle score update is already folded into score_next here.
            if (end_game) begin
                state_next = S_OVER;
                led_next   = '1;
                high_next  = (score_next > high_reg) ? score_next : high_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_meta_reg    <= '0;
            sw_s_reg       <= '0;
            start_meta_reg <= 1'b0;
            start_s_reg    <= 1'b0;
            start_d_reg    <= 1'b0;
            lfsr_reg       <= LFSR_SEED;
            state_reg      <= S_IDLE;
            led_reg        <= '0;
            base_reg       <= '0;
            target_reg     <= '0;
            score_reg      <= '0;
            high_reg       <= '0;
            time_reg       <= TIME_W'(GAME_SECONDS);
            lives_reg      <= 3'(LIVES);
            cnt_reg        <= '0;
`ifdef STREAK_BONUS_EN
            streak_reg     <= '0;
`endif
        end else begin
            sw_meta_reg    <= sw;
            sw_s_reg       <= sw_meta_reg;
            start_meta_reg <= start;
            start_s_reg    <= start_meta_reg;
            start_d_reg    <= start_s_reg;
            lfsr_reg       <= {lfsr_reg[14:0], lfsr_fb};
            state_reg      <= state_next;
            led_reg        <= led_next;
            base_reg       <= base_next;
            target_reg     <= target_next;
            score_reg      <= score_next;
            high_reg       <= high_next;
            time_reg       <= time_next;
            lives_reg      <= lives_next;
            cnt_reg        <= cnt_next;
`ifdef STREAK_BONUS_EN
            streak_reg     <= streak_next;
`endif
        end
    end

    assign led        = led_reg;
    assign score      = score_reg;
    assign high_score = high_reg;
    assign time_left  = time_reg;
    assign lives_left = lives_reg;
    assign game_over  = (state_reg == S_OVER);
    assign playing    = in_play;

endmodule

// File: tb/tb_switch_game_core.sv
// Directed bench for switch_game_core: timeout, answers, lives, restart, reset, saturation and final-tick race.
module tb_switch_game_core;

    localparam int N_SW         = 10;
    localparam int SCORE_W      = 3;
    localparam int TIME_W       = 6;
    localparam int GAME_SECONDS = 3;
    localparam int CLK_HZ       = 40;
    localparam int LIVES        = 2;
    localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [N_SW-1:0]    sw;
    logic [N_SW-1:0]    led;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic [TIME_W-1:0]  time_left;
    logic [2:0]         lives_left;
    logic               playing;
    logic               game_over;
`ifdef STREAK_BONUS_EN
    logic [2:0]         streak;
`endif

    always #5 clk = ~clk;

    switch_game_core #(
        .N_SW(N_SW), .SCORE_W(SCORE_W), .TIME_W(TIME_W), .GAME_SECONDS(GAME_SECONDS),
        .CLK_HZ(CLK_HZ), .LIVES(LIVES), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .sw(sw),
        .led(led),
        .score(score),
        .high_score(high_score),
        .time_left(time_left),
        .lives_left(lives_left),
`ifdef STREAK_BONUS_EN
        .streak(streak),
`endif
        .playing(playing),
        .game_over(game_over)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          t        = 0;
    int          m_score  = 0;
    int          m_streak = 0;
    logic [31:0] exp_q[$];
    logic [N_SW-1:0] lit;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    task automatic wait_to(input int n);
        if (n > t) step(n - t);
    endtask

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] e);
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, e, t);
        end
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_q(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed %0d but no expected value queued", tag, obs);
        end else begin
            compare(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic check_reset_vals();
        compare("rst_led", 32'(led), 0);
        compare("rst_score", 32'(score), 0);
        compare("rst_high", 32'(high_score), 0);
        compare("rst_time", 32'(time_left), GAME_SECONDS);
        compare("rst_lives", 32'(lives_left), LIVES);
        compare("rst_playing", 32'(playing), 0);
        compare("rst_game_over", 32'(game_over), 0);
`ifdef STREAK_BONUS_EN
        compare("rst_streak", 32'(streak), 0);
`endif
    endtask

    // Start edge: 2 sync flops, then PROMPT, then WAIT with the LED lit.
    task automatic start_game();
        start = 1'b1;
        t = 0;
        step(4);
        start = 1'b0;
        m_score  = 0;
        m_streak = 0;
        $display("start: t=%0d score=%0d lives=%0d time=%0d led=%b", t, score, lives_left, time_left, led);
    endtask

    task automatic answer();
        int add;
        lit = led;
        sw  = sw ^ lit;
        add = 1;
`ifdef STREAK_BONUS_EN
        if (m_streak == 4) add = 2;
        else m_streak++;
`endif
        m_score = (m_score + add > SCORE_MAX) ? SCORE_MAX : m_score + add;
        push(32'(m_score));
        step(4);
        check_q("answer_score", 32'(score));
        compare("answer_led_onehot", 32'($onehot(led)), 1);
        compare("answer_playing", 32'(playing), 1);
        $display("answer: t=%0d lit=%b score=%0d new_led=%b", t, lit, score, led);
    endtask

    task automatic wrong();
        logic [N_SW-1:0] mask;
        lit  = led;
        mask = lit[0] ? N_SW'(2) : N_SW'(1);
        sw   = sw ^ mask;
        m_streak = 0;
        step(4);
        $display("wrong: t=%0d lit=%b toggled=%b lives=%0d", t, lit, mask, lives_left);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        sw      = '0;
        step(2);
        check_reset_vals();
        reset_n = 1'b1;
        step(1);

        // Game A: no input, countdown runs out.
        start_game();
        compare("a_playing", 32'(playing), 1);
        compare("a_led_onehot", 32'($onehot(led)), 1);
        wait_to(42);
        compare("a_time_before_tick", 32'(time_left), 3);
        wait_to(43);
        compare("a_time_tick1", 32'(time_left), 2);
        wait_to(83);
        compare("a_time_tick2", 32'(time_left), 1);
        wait_to(122);
        compare("a_not_over_yet", 32'(game_over), 0);
        wait_to(123);
        compare("a_time_zero", 32'(time_left), 0);
        compare("a_game_over", 32'(game_over), 1);
        compare("a_playing_low", 32'(playing), 0);
        compare("a_led_all_ones", 32'(led), 32'((1 << N_SW) - 1));
        compare("a_score", 32'(score), 0);
        step(45);
        compare("a_time_frozen", 32'(time_left), 0);
        $display("game A: t=%0d over=%0d time=%0d", t, game_over, time_left);

        // Game B: four hits then two wrong toggles end the game.
        start_game();
        compare("b_score_cleared", 32'(score), 0);
        compare("b_lives_loaded", 32'(lives_left), LIVES);
        compare("b_time_loaded", 32'(time_left), GAME_SECONDS);
        repeat (4) answer();
        wrong();
        compare("b_lives_1", 32'(lives_left), 1);
        compare("b_still_playing", 32'(playing), 1);
        compare("b_score_kept", 32'(score), 4);
        compare("b_new_prompt", 32'($onehot(led)), 1);
        wrong();
        compare("b_lives_0", 32'(lives_left), 0);
        compare("b_game_over", 32'(game_over), 1);
        compare("b_high", 32'(high_score), 4);
        compare("b_score_hold", 32'(score), 4);
        compare("b_led_all_ones", 32'(led), 32'((1 << N_SW) - 1));

        // Game C: lower score must not replace the high score.
        start_game();
        compare("c_high_kept", 32'(high_score), 4);
        compare("c_score_cleared", 32'(score), 0);
        compare("c_lives_loaded", 32'(lives_left), LIVES);
        repeat (2) answer();
        wait_to(123);
        compare("c_game_over", 32'(game_over), 1);
        compare("c_score", 32'(score), 2);
        compare("c_high_still_4", 32'(high_score), 4);

        // Game D: score saturation, then reset mid-game.
        start_game();
        repeat (9) answer();
        compare("d_score_saturated", 32'(score), SCORE_MAX);
`ifdef STREAK_BONUS_EN
        compare("d_streak_sat", 32'(streak), 4);
`endif
        reset_n = 1'b0;
        step(2);
        check_reset_vals();
        reset_n = 1'b1;
        step(1);

        // Game E: correct answer evaluated on the same cycle as the final tick.
        start_game();
        wait_to(120);
        lit = led;
        sw  = sw ^ lit;
        push(32'd1);
        push(32'd1);
        wait_to(122);
        compare("e_time_before_final", 32'(time_left), 1);
        compare("e_playing_before_final", 32'(playing), 1);
        wait_to(123);
        check_q("e_race_score", 32'(score));
        check_q("e_race_high", 32'(high_score));
        compare("e_race_over", 32'(game_over), 1);
        compare("e_race_time", 32'(time_left), 0);
        compare("e_race_lives", 32'(lives_left), LIVES);
        $display("game E: t=%0d score=%0d high=%0d over=%0d", t, score, high_score, game_over);

        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_game_core.md
Name: switch_game_core

Overview:
- Parametrised next-generation switch-reaction game engine.
- Lights one LED per prompt. The player must toggle exactly that switch. Correct answers score, while wrong toggles cost a life.
- Game ends when the countdown expires or lives run out. A high score is retained across games.
- Sits between board switches/keys and the seven-segment/LED drivers. It outputs binary values only; BCD/segment decode lives outside.

Parameters:
- N_SW, 10: number of switches/LEDs (2..16).
- SCORE_W, 7: score and high_score width.
- TIME_W, 6: time_left width.
- GAME_SECONDS, 20: countdown start value (must fit TIME_W).
- CLK_HZ, 50000000: clk cycles per one-second tick.
- LIVES, 1: wrong toggles allowed before game over (1..7).
- LFSR_SEED, 16'hACE1: nonzero seed of the prompt LFSR.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: synchronous reset, active-low.
- start, input, 1: level; a rising edge (detected internally) starts or restarts a game.
- sw, input, N_SW: raw switch levels; asynchronous.
- led, output, N_SW: prompt LEDs.
- score, output, SCORE_W: current game score.
- high_score, output, SCORE_W: best score since reset.
- time_left, output, TIME_W: remaining seconds.
- lives_left, output, 3: remaining lives.
- playing, output, 1: high in PROMPT/WAIT.
- game_over, output, 1: high in OVER.

Behaviour:
- **Synchronisation:** clk is the only clock. All state updates on posedge clk. `reset_n`=0 at a posedge resets everything.
- **Switch/start inputs:** sw passes through a 2-flop synchroniser (sw_s; 2-cycle latency). start passes through a 2-flop synchroniser plus an edge detector (start_p).
- **Reset values:**
  - state=IDLE, led=0, score=0, high_score=0.
  - time_left=GAME_SECONDS, lives_left=LIVES.
  - playing=0, game_over=0.
  - lfsr=LFSR_SEED, tick counter=0.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Free-runs every cycle in all states, so player timing provides entropy.
- **Prompt index:** idx = lfsr % N_SW.
- **IDLE:**
  - led=0.
  - start_p -> PROMPT. Loads score=0, time_left=GAME_SECONDS, lives_left=LIVES, tick counter=0.
- **PROMPT (exactly 1 cycle):**
  - base=sw_s; target=sw_s ^ (1<<idx); led=(1<<idx).
  - Next state WAIT.
- **WAIT:**
  - led holds the one-hot prompt.
  - If sw_s==base, stay.
  - If sw_s==target (correct): score+1, saturating at 2^SCORE_W-1; next state PROMPT.
  - Any other change (wrong switch, or multiple switches): lives_left-1. If that makes it 0 -> OVER, else -> PROMPT (new prompt built from the current switches).
- **Timer:**
  - Tick counter runs only in PROMPT/WAIT.
  - Counts 0..CLK_HZ-1; tick=1 for one cycle at wrap. Each tick decrements time_left.
  - time_left reaching 0 -> OVER.
  - time_left never underflows and freezes outside play.
- **Simultaneous events in one cycle:**
  - Scoring/life update applies first, then OVER if time hits 0. A correct answer on the final tick counts.
  - Wrong toggle and final tick together: life decremented, then OVER.
- **OVER:**
  - led all ones, game_over=1.
  - On the entry cycle, high_score <= max(high_score, final score), where final score includes the same-cycle increment.
  - score, time_left and lives_left hold.
- **start_p priority:**
  - In any state, start_p restarts the game (IDLE-entry loads, then PROMPT) and takes priority over answer/tick.
  - high_score is kept on restart.
- **Reset mid-game:** returns to IDLE and clears high_score.

Optional Feature:
- Macro: `STREAK_BONUS_EN`.
- **When defined:**
  - An internal 3-bit streak counter increments on each correct answer, saturating at 4, and clears on a wrong toggle or restart.
  - A correct answer with streak already 4 adds 2 instead of 1 (still saturating).
  - Adds output streak [2:0].
- **When undefined:** the counter and port are absent, and every correct answer adds 1.

Test Plan:
- **Basic flow:** CLK_HZ=10, GAME_SECONDS=3. Reset low 2 cycles, sw=0, start pulse, no toggles -> PROMPT after start edge; led one-hot; time_left 3->2->1->0 at 10-cycle ticks; game_over=1, led=all ones, score=0.
- **Correct answers:** read led each prompt and toggle the matching sw bit, 5 times -> score=5; playing=1; led is a new one-hot after each answer (allow 2-cycle sync latency).
- **Lives:** LIVES=2; toggle a non-lit switch twice -> lives_left 2->1 (new prompt), then 1->0 and OVER; high_score=score.
- **Final-tick race:** correct toggle landing on the same cycle as the final tick -> score incremented, then OVER, high_score includes it.
- **Restart:** score 4 in game 1, then restart via start and score 2 -> high_score stays 4. Reset mid-game -> all outputs at reset values, high_score=0.
- **Saturation:** SCORE_W=3, 9 correct answers -> score holds at 7. With `STREAK_BONUS_EN`: the 5th correct answer adds 2 (score 6 after 5 answers).
